alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_core.sv | 46 ++++
 rtl/alu_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the sequential ALU controller
//
// Purpose : opcode enum, FSM state enum and default datapath width used by
//           alu_seq_ctrl and alu_core.
// Contents: ALU_SEQ_W_DEF, op_e, state_e

package alu_seq_pkg;

  localparam int ALU_SEQ_W_DEF = 5;

  typedef enum logic [1:0] {
    OP_XOR   = 2'b00,
    OP_ROR   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational XOR / rotate-right / load / clear datapath with zero flag
//
// Purpose : computes the next accumulator value from operand A (accumulator),
//           operand B and the opcode; flags a zero result.
// Ports   : i_a      in  W  operand A (current accumulator)
//           i_b      in  W  operand B / load value
//           i_op     in  2  opcode (op_e)
//           o_result out W  next accumulator value
//           o_zf     out 1  high when o_result == 0

module alu_core
  import alu_seq_pkg::*;
#(
  parameter int W = ALU_SEQ_W_DEF
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  op_e          i_op,
  output logic [W-1:0] o_result,
  output logic         o_zf
);

  localparam logic [W-1:0] W_L = W'(W);

  logic [W-1:0] w_amt;
  logic [W-1:0] w_ror;

  // Rotate amount is B mod W. An amount of 0 makes the left shift equal to W,
  // which clears that term, so the rotate naturally returns i_a unchanged.
  assign w_amt = i_b % W_L;
  assign w_ror = (i_a >> w_amt) | (i_a << (W_L - w_amt));

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_XOR:   o_result = i_a ^ i_b;
      OP_ROR:   o_result = w_ror;
      OP_LOAD:  o_result = i_b;
      OP_CLEAR: o_result = '0;
      default:  o_result = '0;
    endcase
  end

  assign o_zf = (o_result == '0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - command/response sequenced accumulator ALU (IDLE -> EXEC -> RESP)
//
// Purpose : accepts one command in IDLE, updates the accumulator in EXEC and
//           presents the registered result in RESP until it is consumed.
// Ports   : clk        in  1  clock, rising edge
//           rst_n      in  1  asynchronous active-low reset
//           cmd_valid  in  1  command offered
//           cmd_ready  out 1  high only in IDLE
//           cmd_op     in  2  00 XOR, 01 ROR, 10 LOAD, 11 CLEAR
//           cmd_data   in  W  operand B or load value
//           rsp_valid  out 1  result available (RESP)
//           rsp_ready  in  1  result consumed
//           rsp_data   out W  accumulator after the command
//           rsp_zf     out 1  rsp_data == 0
//           busy       out 1  state != IDLE
//           op_count   out 8  completed responses, wrapping (only with ALU_SEQ_OPCNT_EN)
// Macro   : ALU_SEQ_OPCNT_EN enables the op_count output and counter.

module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int W = ALU_SEQ_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_zf,
  output logic         busy
`ifdef ALU_SEQ_OPCNT_EN
  ,
  output logic [7:0]   op_count
`endif
);

  state_e       r_state;
  state_e       w_next_state;
  op_e          r_op;
  logic [W-1:0] r_b;
  logic [W-1:0] r_acc;
  logic         r_zf;

  logic         w_accept;
  logic         w_rsp_done;
  logic [W-1:0] w_result;
  logic         w_result_zf;

  assign w_accept   = cmd_valid && cmd_ready;
  assign w_rsp_done = rsp_valid && rsp_ready;

  alu_core #(
    .W (W)
  ) u_alu_core (
    .i_a      (r_acc),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_result),
    .o_zf     (w_result_zf)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_next_state = ST_EXEC;
      ST_EXEC:                 w_next_state = ST_RESP;
      ST_RESP: if (w_rsp_done) w_next_state = ST_IDLE;
      default:                 w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only, so they are glitch-free
  // and stay fixed while the response is held off.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Command capture and accumulator update. The operand is latched at accept
  // so later cmd_data changes cannot affect the issued command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= OP_XOR;
      r_b   <= '0;
      r_acc <= '0;
      r_zf  <= 1'b1;
    end else begin
      if (w_accept) begin
        r_op <= op_e'(cmd_op);
        r_b  <= cmd_data;
      end
      if (r_state == ST_EXEC) begin
        r_acc <= w_result;
        r_zf  <= w_result_zf;
      end
    end
  end

  assign rsp_data = r_acc;
  assign rsp_zf   = r_zf;

`ifdef ALU_SEQ_OPCNT_EN
  logic [7:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= 8'd0;
    end else if (w_rsp_done) begin
      r_op_count <= r_op_count + 8'd1;
    end
  end

  assign op_count = r_op_count;
`else
  // No completed-response counter in this build.
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl

module tb_alu_seq_ctrl;

  localparam int W    = 5;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_zf;
  logic         busy;
`ifdef ALU_SEQ_OPCNT_EN
  logic [7:0]   op_count;
`endif

  alu_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zf    (rsp_zf),
    .busy      (busy)
`ifdef ALU_SEQ_OPCNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_acc = 0;

  typedef struct {
    logic [1:0] op;
    int         data;
    int         exp_d;
    int         exp_z;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Reference: accumulator update written directly from the opcode rules.
  function automatic int model(input int a, input int op, input int b);
    int k;
    case (op)
      0: return (a ^ b) & MASK;
      1: begin
        k = b % W;
        if (k == 0) return a;
        return ((a >> k) | (a << (W - k))) & MASK;
      end
      2: return b & MASK;
      default: return 0;
    endcase
  endfunction

  // Issue one command, measure latency, optionally hold off the response
  // (offering a CLEAR meanwhile), then consume it.
  task automatic do_cmd(input logic [1:0] op, input int data, input int hold,
                        input bit offer_clear, input int exp_d, input int exp_z,
                        input string tag);
    int lat;
    @(negedge clk);
    chk({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data[W-1:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = W'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 2);
    chk({tag, ".data"}, 32'(rsp_data), 32'(exp_d));
    chk({tag, ".zf"}, 32'(rsp_zf), 32'(exp_z));
    for (int i = 0; i < hold; i++) begin
      if (offer_clear) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
      end
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 1);
      chk({tag, ".hold_data"}, 32'(rsp_data), 32'(exp_d));
      chk({tag, ".hold_zf"}, 32'(rsp_zf), 32'(exp_z));
      chk({tag, ".hold_cmd_ready"}, 32'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(rsp_valid), 0);
    chk({tag, ".post_cmd_ready"}, 32'(cmd_ready), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".rsp_zf"}, 32'(rsp_zf), 1);
    chk({tag, ".rsp_data"}, 32'(rsp_data), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int op, data, hold, e;

    vt[0] = '{2'b10, 21, 21, 0};
    vt[1] = '{2'b00, 21,  0, 1};
    vt[2] = '{2'b10,  3,  3, 0};
    vt[3] = '{2'b01,  1, 17, 0};
    vt[4] = '{2'b01,  7, 12, 0};
    vt[5] = '{2'b01,  5, 12, 0};
    vt[6] = '{2'b11,  9,  0, 1};
    vt[7] = '{2'b00, 31, 31, 0};

    // Power-on reset
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_cmd(vt[i].op, vt[i].data, 0, 1'b0, vt[i].exp_d, vt[i].exp_z, $sformatf("vec%0d", i));
    end
    m_acc = 31;

    // Backpressure with a CLEAR offered while the response is held
    do_cmd(2'b10, 11, 3, 1'b1, 11, 0, "bp_load");
    do_cmd(2'b00, 0, 0, 1'b0, 11, 0, "bp_after");

    // Reset during EXEC of XOR 11111
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 5'b11111;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("exec_rst.busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("exec_rst");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("exec_rst.no_rsp", 32'(seen), 0);
    chk("exec_rst.acc", 32'(rsp_data), 0);
    m_acc = 0;
    do_cmd(2'b00, 0, 0, 1'b0, 0, 1, "exec_rst_xor0");

    // Reset mid-run while a response is pending
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 5'b00111;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("resp_rst.valid_before", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("resp_rst");
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = 0;
    do_cmd(2'b00, 0, 0, 1'b0, 0, 1, "resp_rst_xor0");

    // Randomized commands against the reference model
    for (int n = 0; n < 150; n++) begin
      op   = $urandom_range(0, 3);
      data = $urandom_range(0, MASK);
      hold = $urandom_range(0, 2);
      e    = model(m_acc, op, data);
      do_cmd(2'(op), data, hold, hold[0], e, (e == 0) ? 1 : 0, $sformatf("rnd%0d", n));
      m_acc = e;
    end

`ifdef ALU_SEQ_OPCNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("opcnt.reset", 32'(op_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = 0;
    for (int n = 0; n < 3; n++) do_cmd(2'b11, 0, 0, 1'b0, 0, 1, "opcnt_a");
    chk("opcnt.three", 32'(op_count), 3);
    for (int n = 0; n < 253; n++) do_cmd(2'b11, 0, 0, 1'b0, 0, 1, "opcnt_b");
    chk("opcnt.wrap", 32'(op_count), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
